// File: rtl/fc_pkg.sv
// Shared sizes, controller state encoding and score saturation for fc_classifier.
package fc_pkg;

    localparam int NUM_IN  = 225;
    localparam int NUM_OUT = 4;
    localparam int IN_W    = 22;
    localparam int WT_W    = 8;
    localparam int BIAS_W  = 16;
    localparam int SHIFT   = 7;
    localparam int ACC_W   = IN_W + WT_W + $clog2(NUM_IN);
    localparam int PROD_W  = IN_W + WT_W;
    localparam int CNT_W   = $clog2(NUM_IN);
    localparam int IDX_W   = $clog2(NUM_OUT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCUM  = 3'd1,
        S_FINISH = 3'd2,
        S_EMIT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (IN_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - 1;

    // Clamp a scaled accumulator value into the signed feature range.
    function automatic logic signed [IN_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[IN_W-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[IN_W-1:0];
        end
        return v[IN_W-1:0];
    endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One output neuron: weight/bias storage, multiply-accumulate with clear, and
// bias/shift/saturate into a registered score. FC_RELU_EN clamps negative scores to 0.
module fc_mac_lane
    import fc_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_acc_en,
    input  logic signed [IN_W-1:0]   i_feature,
    input  logic        [CNT_W-1:0]  i_cnt,
    input  logic                     i_we_wt,
    input  logic                     i_we_bias,
    input  logic        [CNT_W-1:0]  i_wt_index,
    input  logic        [BIAS_W-1:0] i_wt_data,
    input  logic                     i_finish,
    output logic        [IN_W-1:0]   o_score
);

    logic signed [WT_W-1:0]   r_wt_mem [NUM_IN];
    logic signed [BIAS_W-1:0] r_bias;
    logic signed [ACC_W-1:0]  r_acc;
    logic        [IN_W-1:0]   r_score;

    logic signed [WT_W-1:0]   w_wt;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  w_scaled;
    logic signed [IN_W-1:0]   w_sat;
    logic        [IN_W-1:0]   w_score_next;

    // Coefficient storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (i_we_wt) begin
            r_wt_mem[i_wt_index] <= i_wt_data[WT_W-1:0];
        end
        if (i_we_bias) begin
            r_bias <= i_wt_data;
        end
    end

    assign w_wt       = r_wt_mem[i_cnt];
    assign w_prod     = i_feature * w_wt;
    assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_acc_en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

    assign w_sum    = r_acc + {{(ACC_W-BIAS_W){r_bias[BIAS_W-1]}}, r_bias};
    assign w_scaled = w_sum >>> SHIFT;
    assign w_sat    = saturate(w_scaled);

`ifdef FC_RELU_EN
    assign w_score_next = w_sat[IN_W-1] ? '0 : w_sat;
`else
    assign w_score_next = w_sat;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_score <= '0;
        end else if (i_finish) begin
            r_score <= w_score_next;
        end
    end

    assign o_score = r_score;

endmodule

// File: rtl/fc_classifier.sv
// Fully-connected output stage: NUM_OUT parallel MAC lanes under one frame controller,
// scores emitted serially. Optional ReLU on scores via FC_RELU_EN (see fc_mac_lane).
module fc_classifier
    import fc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_signal,
    input  logic              feature_valid_in,
    input  logic [IN_W-1:0]   feature_in,
    input  logic              wt_we,
    input  logic              wt_is_bias,
    input  logic [IDX_W-1:0]  wt_neuron,
    input  logic [CNT_W-1:0]  wt_index,
    input  logic [BIAS_W-1:0] wt_data,
    output logic [IN_W-1:0]   result_out,
    output logic [IDX_W-1:0]  result_index,
    output logic              result_valid,
    output logic              done_signal,
    output logic              busy
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;

    logic             w_accept;
    logic             w_last;
    logic             w_wt_wr;
    logic             w_bias_wr;
    logic [IN_W-1:0]  w_score [NUM_OUT];

    // A start pulse always wins over a feature arriving in the same cycle.
    assign w_accept  = (r_state == S_ACCUM) && feature_valid_in && !start_signal;
    assign w_last    = w_accept && (r_cnt == CNT_W'(NUM_IN - 1));
    assign w_wt_wr   = wt_we && (r_state == S_IDLE) && !wt_is_bias && (wt_index < CNT_W'(NUM_IN));
    assign w_bias_wr = wt_we && (r_state == S_IDLE) && wt_is_bias;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else if (start_signal) begin
            r_state <= S_ACCUM;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_ACCUM: begin
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_state <= S_FINISH;
                    end else if (w_accept) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FINISH: begin
                    r_idx   <= '0;
                    r_state <= S_EMIT;
                end
                S_EMIT: begin
                    if (r_idx == IDX_W'(NUM_OUT - 1)) begin
                        r_idx   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_lane
            fc_mac_lane u_lane (
                .clk        (clk),
                .rst        (rst),
                .i_clear    (start_signal),
                .i_acc_en   (w_accept),
                .i_feature  (feature_in),
                .i_cnt      (r_cnt),
                .i_we_wt    (w_wt_wr && (wt_neuron == IDX_W'(gi))),
                .i_we_bias  (w_bias_wr && (wt_neuron == IDX_W'(gi))),
                .i_wt_index (wt_index),
                .i_wt_data  (wt_data),
                .i_finish   (r_state == S_FINISH),
                .o_score    (w_score[gi])
            );
        end
    endgenerate

    assign result_valid = (r_state == S_EMIT);
    assign result_index = r_idx;
    assign result_out   = result_valid ? w_score[r_idx] : '0;
    assign done_signal  = (r_state == S_DONE);
    assign busy         = (r_state != S_IDLE);

endmodule

// File: doc/fc_classifier.md
Name: fc_classifier

Overview:
- Fully-connected output stage directly downstream of the feature extractor; consumes its 225-feature stream (15x15 pooled map, 22-bit signed, raster order).
- Computes NUM_OUT dot products against an internal signed weight array, adds a per-neuron bias, scales and saturates the sums, then emits one score per neuron serially.
- Weights and biases are loaded over a simple write port while idle.

Parameters:
- NUM_IN, 225, features per frame
- NUM_OUT, 4, output neurons, computed in parallel
- IN_W, 22, feature width (signed)
- WT_W, 8, weight width (signed)
- BIAS_W, 16, bias width (signed, at accumulator scale)
- SHIFT, 7, arithmetic right shift applied before saturation
- ACC_W, 38, accumulator width (IN_W+WT_W+clog2(NUM_IN))

Ports:
- clk  in  1  clock, single domain
- rst  in  1  asynchronous active-low reset
- start_signal  in  1  one-cycle pulse; clears accumulators, begins frame
- feature_valid_in  in  1  feature_in qualifier
- feature_in  in  IN_W  signed feature
- wt_we  in  1  weight/bias write strobe
- wt_is_bias  in  1  1 = write bias[wt_neuron]; 0 = weight
- wt_neuron  in  clog2(NUM_OUT)  target neuron
- wt_index  in  clog2(NUM_IN)  target feature index
- wt_data  in  BIAS_W  write data; weights use low WT_W bits
- result_out  out  IN_W  signed saturated score
- result_index  out  clog2(NUM_OUT)  neuron of result_out
- result_valid  out  1  result qualifier
- done_signal  out  1  one-cycle frame-complete pulse
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset, asynchronous: state IDLE; accumulators, feature counter, result_out, result_index = 0; result_valid, done_signal, busy = 0. Weight and bias arrays are not reset.
- States:
  - IDLE: on start_signal go to ACCUM.
  - ACCUM: on each feature_valid_in, acc[o] += feature_in * w[o][cnt] for all o, and cnt++. The product is full-precision signed and sign-extended to ACC_W. When the NUM_IN-th feature is accepted, go to FINISH.
  - FINISH, 1 cycle: y[o] = (acc[o] + sext(bias[o])) >>> SHIFT (floor). Saturate y[o] to [-2^(IN_W-1), 2^(IN_W-1)-1]. Register into out_reg[o].
  - EMIT, NUM_OUT cycles: result_valid = 1, result_index = 0..NUM_OUT-1 in order, result_out = out_reg[index].
  - DONE, 1 cycle: done_signal = 1, then go to IDLE.
- Latency: last feature accepted at edge T. First result_valid is in cycle T+2 and the last is in T+1+NUM_OUT. done_signal follows in T+2+NUM_OUT.
- start_signal in ACCUM, FINISH, EMIT or DONE aborts the frame: clear accumulators and counter, result_valid drops, go to ACCUM. No done_signal is issued for the aborted frame.
- feature_valid_in outside ACCUM is ignored. Gaps between valid features are allowed. Fewer than NUM_IN features means the block waits indefinitely.
- wt_we is honoured only in IDLE and silently dropped otherwise. A weight write stores wt_data[WT_W-1:0].
- Simultaneous wt_we and start_signal in IDLE: the write completes and the frame starts.
- Reset asserted mid-frame returns to IDLE at once with all outputs at reset values.

Optional Feature:
- Macro FC_RELU_EN.
- Defined: in FINISH, a negative saturated y[o] is replaced by 0 before registering.
- Undefined: signed scores are passed through unchanged.
- Timing is identical either way.

Decomposition:
- Package fc_pkg holds: NUM_IN, NUM_OUT, widths, a state enum typedef (IDLE, ACCUM, FINISH, EMIT, DONE), and a saturate function.
- One sub-module, fc_mac_lane: one neuron's multiplier, accumulator with clear, and bias/shift/saturate. It is instantiated NUM_OUT times under a shared controller.

Test Plan:
- All weights 64, biases 0; 225 features of value 2 -> four results of 225 (28800>>>7), indices 0..3, done_signal one cycle after the last.
- Neuron 0 weights -64, feature 100 x225 -> result -11250; with FC_RELU_EN -> 0. Other neurons are unaffected.
- Weights 127, features 2097151 x225 -> result 2097151. Weights -128 -> result -2097152. Covers saturation both ways.
- Bias 1280 on neuron 2, weights 0, any features -> neuron 2 = 10, others 0.
- 100 features, then start_signal, then 225 features of 2 at weight 64 -> 225 (the aborted frame does not leak). Random valid gaps give the same result; wt_we during ACCUM leaves weights unchanged.
- rst low during EMIT -> result_valid, done_signal and busy go to 0 immediately. A fresh frame after reset produces correct results.
